// File: rtl/am2940_pkg.sv
// Shared definitions for the AM2940 DMA address generator control slice.
// Holds the instruction and count-mode encodings and the bit positions of
// the fields inside the 3-bit control register.
package am2940_pkg;

  typedef enum logic [2:0] {
    WR_CR   = 3'd0,
    RD_CR   = 3'd1,
    RD_WC   = 3'd2,
    RD_AC   = 3'd3,
    REINIT  = 3'd4,
    LD_ADDR = 3'd5,
    LD_WC   = 3'd6,
    ENABLE  = 3'd7
  } instr_t;

  typedef enum logic [1:0] {
    WC_DOWN   = 2'b00,
    WC_UP_CMP = 2'b01,
    ADDR_CMP  = 2'b10,
    WC_WRAP   = 2'b11
  } mode_t;

  // Control register layout: cr[1:0] count mode, cr[2] address direction
  // (0 increment, 1 decrement).
  localparam int CR_MODE_LSB = 0;
  localparam int CR_MODE_MSB = 1;
  localparam int CR_DIR      = 2;

endpackage

// File: rtl/am2940_if.sv
// Connection between the AM2940 control unit and the address counter.
//   a_pl    parallel-load strobe          a_di   load data
//   a_encnt count enable                  a_ci   carry-in (active-low)
//   a_inc   count up                      a_dec  count down
//   aq      current counter value, returned to the control unit
// master: control unit side; slave: address counter side.
interface am2940_if #(
  parameter int W = 8
);
  logic [W-1:0] aq;
  logic [W-1:0] a_di;
  logic         a_pl;
  logic         a_encnt;
  logic         a_ci;
  logic         a_inc;
  logic         a_dec;

  modport master (
    output a_pl, a_di, a_encnt, a_ci, a_inc, a_dec,
    input  aq
  );

  modport slave (
    input  a_pl, a_di, a_encnt, a_ci, a_inc, a_dec,
    output aq
  );
endinterface

// File: rtl/am2940_word_cnt.sv
// Word-count holding register, word counter and DONE generation.
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-low clear
//   instr        current instruction
//   din          data bus (new control word / word count)
//   cin_n        active-low count enable
//   mode         count mode from the control register
//   aq           address counter value (for address-compare mode)
//   wc           current word counter, for read-back
//   done         transfer complete
//   stopped      counting is frozen because done is set in a stopping mode
module am2940_word_cnt
  import am2940_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  instr_t       instr,
  input  logic [W-1:0] din,
  input  logic         cin_n,
  input  mode_t        mode,
  input  logic [W-1:0] aq,
  output logic [W-1:0] wc,
  output logic         done,
  output logic         stopped
);

  logic [W-1:0] wc_reg;

  // In wrap mode done is only a one-cycle marker of the 0 -> all-ones step,
  // so it depends on the live instruction and carry-in, not just state.
  always_comb begin
    case (mode)
      WC_DOWN:   done = (wc == '0);
      WC_UP_CMP: done = (wc == wc_reg);
      ADDR_CMP:  done = (aq == wc_reg);
      default:   done = (wc == '0) && (instr == ENABLE) && !cin_n;
    endcase
    stopped = done && (mode != WC_WRAP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wc_reg <= '0;
      wc     <= '0;
    end else begin
      case (instr)
        WR_CR: begin
          // Up-compare counts from zero; switching into it restarts the count.
          if (mode_t'(din[1:0]) == WC_UP_CMP) wc <= '0;
        end
        LD_WC: begin
          wc_reg <= din;
          wc     <= (mode == WC_UP_CMP) ? '0 : din;
        end
        REINIT: begin
          wc <= (mode == WC_UP_CMP) ? '0 : wc_reg;
        end
        ENABLE: begin
          if (!cin_n && !stopped) begin
            case (mode)
              WC_UP_CMP:        wc <= wc + 1'b1;
              WC_DOWN, WC_WRAP: wc <= wc - 1'b1;
              default:          wc <= wc;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/am2940_ctrl.sv
// AM2940 instruction decoder and word-count/done unit. Owns the control
// register and address holding register, drives the address counter and
// multiplexes internal state onto the read-back bus.
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-low clear
//   instr        instruction, decoded every cycle
//   din          data bus input
//   cin_n        active-low count enable
//   cnt          address counter connection (master side)
//   done         transfer complete
//   dout, oe     read-back data and its valid flag
module am2940_ctrl
  import am2940_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  instr_t       instr,
  input  logic [W-1:0] din,
  input  logic         cin_n,
  am2940_if.master     cnt,
  output logic         done,
  output logic [W-1:0] dout,
  output logic         oe
);

  logic [2:0]   cr;
  logic [W-1:0] addr_reg;
  logic [W-1:0] wc;
  logic         stopped;
  mode_t        mode;

  assign mode = mode_t'(cr[CR_MODE_MSB:CR_MODE_LSB]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cr       <= '0;
      addr_reg <= '0;
    end else begin
      if (instr == WR_CR)   cr       <= din[2:0];
      if (instr == LD_ADDR) addr_reg <= din;
    end
  end

  am2940_word_cnt #(.W(W)) u_wc (
    .clk     (clk),
    .reset   (reset),
    .instr   (instr),
    .din     (din),
    .cin_n   (cin_n),
    .mode    (mode),
    .aq      (cnt.aq),
    .wc      (wc),
    .done    (done),
    .stopped (stopped)
  );

  // LD_ADDR loads the counter straight from din on the same edge that
  // addr_reg captures it; REINIT reloads from the saved copy.
  assign cnt.a_pl    = (instr == LD_ADDR) || (instr == REINIT);
  assign cnt.a_di    = (instr == REINIT) ? addr_reg : din;
  assign cnt.a_encnt = (instr == ENABLE) && !stopped;
  assign cnt.a_ci    = cin_n;
  assign cnt.a_inc   = !cr[CR_DIR];
  assign cnt.a_dec   = cr[CR_DIR];

  always_comb begin
    oe   = 1'b0;
    dout = '0;
    case (instr)
      RD_CR: begin
        oe   = 1'b1;
        dout = {{(W-3){1'b0}}, cr};
      end
      RD_WC: begin
        oe   = 1'b1;
        dout = wc;
      end
      RD_AC: begin
        oe   = 1'b1;
        dout = cnt.aq;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_am2940_ctrl.sv
// Self-checking bench for am2940_ctrl. Expected counter/done/enable values
// are queued as each stimulus is driven and popped when the result is read.
module tb_am2940_ctrl;
  import am2940_pkg::*;

  logic       clk;
  logic       reset;
  instr_t     instr;
  logic [7:0] din;
  logic       cin_n;
  logic       done;
  logic [7:0] dout;
  logic       oe;

  am2940_if #(.W(8)) cnt_if ();

  am2940_ctrl #(.W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .instr (instr),
    .din   (din),
    .cin_n (cin_n),
    .cnt   (cnt_if),
    .done  (done),
    .dout  (dout),
    .oe    (oe)
  );

  typedef struct {
    logic [7:0] wc;
    logic       done;
    logic       encnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input instr_t i, input logic [7:0] d, input logic c);
    instr = i;
    din   = d;
    cin_n = c;
    @(posedge clk);
    #1;
  endtask

  task automatic read_wc(output logic [7:0] v);
    instr_t saved;
    saved = instr;
    instr = RD_WC;
    #1;
    v = dout;
    instr = saved;
    #1;
  endtask

  task automatic pop_exp(output exp_t e);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_underflow got empty queue expected entry");
      e = '{8'h00, 1'b0, 1'b0};
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset = 1'b1; instr = ENABLE; din = 8'h00; cin_n = 1'b0; cnt_if.aq = 8'h00;
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (oe !== 1'b0) begin miscompares++; $display("FAIL rst_oe got %b expected 0", oe); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rst_done got %b expected 1", done); end
    vectors++; if (cnt_if.a_encnt !== 1'b0) begin miscompares++; $display("FAIL rst_encnt got %b expected 0", cnt_if.a_encnt); end
    read_wc(v);
    vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL rst_wc got %h expected 00", v); end
    instr = RD_CR; #1;
    vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL rst_cr got %h expected 00", dout); end
    instr = ENABLE; #1;
    reset = 1'b1; #1;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rel_done got %b expected 1", done); end
    vectors++; if (cnt_if.a_encnt !== 1'b0) begin miscompares++; $display("FAIL rel_encnt got %b expected 0", cnt_if.a_encnt); end
    tick(ENABLE, 8'h00, 1'b0);
    read_wc(v);
    vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL rel_wc_hold got %h expected 00", v); end
  endtask

  task automatic test_wc_down();
    exp_t e;
    logic [7:0] v;
    tick(WR_CR, 8'd0, 1'b1);
    tick(LD_WC, 8'd3, 1'b1);
    instr = LD_ADDR; din = 8'd10; #1;
    vectors++; if (cnt_if.a_pl !== 1'b1) begin miscompares++; $display("FAIL ldaddr_pl got %b expected 1", cnt_if.a_pl); end
    vectors++; if (cnt_if.a_di !== 8'd10) begin miscompares++; $display("FAIL ldaddr_di got %h expected 0a", cnt_if.a_di); end
    vectors++; if (cnt_if.a_inc !== 1'b1 || cnt_if.a_dec !== 1'b0) begin miscompares++; $display("FAIL down_dir got inc=%b dec=%b expected inc=1 dec=0", cnt_if.a_inc, cnt_if.a_dec); end
    @(posedge clk); #1;
    exp_q.push_back('{8'd2, 1'b0, 1'b1});
    exp_q.push_back('{8'd1, 1'b0, 1'b1});
    exp_q.push_back('{8'd0, 1'b1, 1'b0});
    exp_q.push_back('{8'd0, 1'b1, 1'b0});
    for (int k = 0; k < 4; k++) begin
      tick(ENABLE, 8'h00, 1'b0);
      pop_exp(e);
      vectors++; if (done !== e.done) begin miscompares++; $display("FAIL down_done[%0d] got %b expected %b", k, done, e.done); end
      vectors++; if (cnt_if.a_encnt !== e.encnt) begin miscompares++; $display("FAIL down_encnt[%0d] got %b expected %b", k, cnt_if.a_encnt, e.encnt); end
      read_wc(v);
      vectors++; if (v !== e.wc) begin miscompares++; $display("FAIL down_wc[%0d] got %h expected %h", k, v, e.wc); end
    end
    cnt_if.aq = 8'h37; instr = RD_AC; #1;
    vectors++; if (oe !== 1'b1 || dout !== 8'h37) begin miscompares++; $display("FAIL rd_ac got oe=%b dout=%h expected oe=1 dout=37", oe, dout); end
    cnt_if.aq = 8'h00; instr = ENABLE; cin_n = 1'b1; #1;
  endtask

  task automatic test_up_cmp();
    exp_t e;
    logic [7:0] v;
    tick(WR_CR, 8'd5, 1'b1);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL up_mode_done got %b expected 0", done); end
    vectors++; if (cnt_if.a_dec !== 1'b1 || cnt_if.a_inc !== 1'b0) begin miscompares++; $display("FAIL up_dir got inc=%b dec=%b expected inc=0 dec=1", cnt_if.a_inc, cnt_if.a_dec); end
    tick(LD_WC, 8'd2, 1'b1);
    read_wc(v);
    vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL up_ldwc_wc got %h expected 00", v); end
    exp_q.push_back('{8'd1, 1'b0, 1'b1});
    exp_q.push_back('{8'd2, 1'b1, 1'b0});
    for (int k = 0; k < 2; k++) begin
      tick(ENABLE, 8'h00, 1'b0);
      pop_exp(e);
      vectors++; if (done !== e.done) begin miscompares++; $display("FAIL up_done[%0d] got %b expected %b", k, done, e.done); end
      vectors++; if (cnt_if.a_encnt !== e.encnt) begin miscompares++; $display("FAIL up_encnt[%0d] got %b expected %b", k, cnt_if.a_encnt, e.encnt); end
      read_wc(v);
      vectors++; if (v !== e.wc) begin miscompares++; $display("FAIL up_wc[%0d] got %h expected %h", k, v, e.wc); end
    end
    instr = REINIT; #1;
    vectors++; if (cnt_if.a_pl !== 1'b1 || cnt_if.a_di !== 8'd10) begin miscompares++; $display("FAIL reinit_drive got pl=%b di=%h expected pl=1 di=0a", cnt_if.a_pl, cnt_if.a_di); end
    @(posedge clk); #1;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reinit_done got %b expected 0", done); end
    read_wc(v);
    vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL reinit_wc got %h expected 00", v); end
    tick(LD_WC, 8'd0, 1'b1);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL up_zero_done got %b expected 1", done); end
    instr = ENABLE; cin_n = 1'b0; #1;
    vectors++; if (cnt_if.a_encnt !== 1'b0) begin miscompares++; $display("FAIL up_zero_encnt got %b expected 0", cnt_if.a_encnt); end
  endtask

  task automatic test_addr_cmp();
    exp_t e;
    logic [7:0] v;
    logic [7:0] aq_seq [3];
    aq_seq[0] = 8'd18; aq_seq[1] = 8'd19; aq_seq[2] = 8'd20;
    tick(WR_CR, 8'd2, 1'b1);
    tick(LD_WC, 8'd20, 1'b1);
    instr = ENABLE; cin_n = 1'b0;
    exp_q.push_back('{8'd20, 1'b0, 1'b1});
    exp_q.push_back('{8'd20, 1'b0, 1'b1});
    exp_q.push_back('{8'd20, 1'b1, 1'b0});
    for (int k = 0; k < 3; k++) begin
      cnt_if.aq = aq_seq[k]; #1;
      pop_exp(e);
      vectors++; if (done !== e.done) begin miscompares++; $display("FAIL acmp_done[%0d] got %b expected %b", k, done, e.done); end
      vectors++; if (cnt_if.a_encnt !== e.encnt) begin miscompares++; $display("FAIL acmp_encnt[%0d] got %b expected %b", k, cnt_if.a_encnt, e.encnt); end
      @(posedge clk); #1;
      read_wc(v);
      vectors++; if (v !== e.wc) begin miscompares++; $display("FAIL acmp_wc[%0d] got %h expected %h", k, v, e.wc); end
    end
    instr = WR_CR; din = 8'd0; cin_n = 1'b1; #1;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL modechg_before got %b expected 1", done); end
    @(posedge clk); #1;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL modechg_after got %b expected 0", done); end
    cnt_if.aq = 8'h00;
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [7:0] v;
    tick(WR_CR, 8'd3, 1'b1);
    tick(LD_WC, 8'd1, 1'b1);
    instr = ENABLE; cin_n = 1'b0; #1;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL wrap_pre_done got %b expected 0", done); end
    exp_q.push_back('{8'h00, 1'b1, 1'b1});
    exp_q.push_back('{8'hFF, 1'b0, 1'b1});
    exp_q.push_back('{8'hFE, 1'b0, 1'b1});
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      pop_exp(e);
      vectors++; if (done !== e.done) begin miscompares++; $display("FAIL wrap_done[%0d] got %b expected %b", k, done, e.done); end
      vectors++; if (cnt_if.a_encnt !== e.encnt) begin miscompares++; $display("FAIL wrap_encnt[%0d] got %b expected %b", k, cnt_if.a_encnt, e.encnt); end
      if (k == 0) begin
        cin_n = 1'b1; #1;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL wrap_cin_done got %b expected 0", done); end
        cin_n = 1'b0; #1;
      end
      read_wc(v);
      vectors++; if (v !== e.wc) begin miscompares++; $display("FAIL wrap_wc[%0d] got %h expected %h", k, v, e.wc); end
    end
  endtask

  task automatic test_hold_read();
    logic [7:0] v;
    tick(ENABLE, 8'h00, 1'b1);
    vectors++; if (cnt_if.a_ci !== 1'b1) begin miscompares++; $display("FAIL hold_ci got %b expected 1", cnt_if.a_ci); end
    read_wc(v);
    vectors++; if (v !== 8'hFE) begin miscompares++; $display("FAIL hold_wc got %h expected fe", v); end
    instr = RD_CR; #1;
    vectors++; if (oe !== 1'b1 || dout !== 8'h03) begin miscompares++; $display("FAIL rd_cr got oe=%b dout=%h expected oe=1 dout=03", oe, dout); end
    instr = RD_WC; #1;
    vectors++; if (oe !== 1'b1 || dout !== 8'hFE) begin miscompares++; $display("FAIL rd_wc got oe=%b dout=%h expected oe=1 dout=fe", oe, dout); end
    @(posedge clk); #1;
    read_wc(v);
    vectors++; if (v !== 8'hFE) begin miscompares++; $display("FAIL rd_side_effect got %h expected fe", v); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    tick(WR_CR, 8'd0, 1'b1);
    tick(LD_WC, 8'd5, 1'b1);
    tick(ENABLE, 8'h00, 1'b0);
    read_wc(v);
    vectors++; if (v !== 8'd4) begin miscompares++; $display("FAIL mid_pre_wc got %h expected 04", v); end
    reset = 1'b0; #1;
    vectors++; if (done !== 1'b1 || cnt_if.a_encnt !== 1'b0 || oe !== 1'b0) begin miscompares++; $display("FAIL mid_rst_out got done=%b encnt=%b oe=%b expected 1 0 0", done, cnt_if.a_encnt, oe); end
    read_wc(v);
    vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL mid_rst_wc got %h expected 00", v); end
    instr = REINIT; #1;
    vectors++; if (cnt_if.a_di !== 8'h00) begin miscompares++; $display("FAIL mid_rst_addr got %h expected 00", cnt_if.a_di); end
    instr = ENABLE;
    @(posedge clk); #1;
    reset = 1'b1; #1;
    vectors++; if (done !== 1'b1 || cnt_if.a_encnt !== 1'b0) begin miscompares++; $display("FAIL mid_rel got done=%b encnt=%b expected 1 0", done, cnt_if.a_encnt); end
    tick(ENABLE, 8'h00, 1'b0);
    read_wc(v);
    vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL mid_rel_wc got %h expected 00", v); end
  endtask

  initial begin
    test_reset();
    test_wc_down();
    test_up_cmp();
    test_addr_cmp();
    test_wrap();
    test_hold_read();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/am2940_ctrl.md
Name: am2940_ctrl

Overview:
- Instruction decoder and word-count/done unit of the AM2940 DMA address generator.
- Sits directly upstream of the 8-bit address counter and drives its pl/ci/inc/dec/encnt/di inputs.
- Owns the control register, address and word-count holding registers, the word counter and the DONE logic.
- Multiplexes internal state onto the read-back data bus.

Parameters:
- W, 8, data, address and word-count width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; clears all registers while low.
- instr  in  3  instruction, decoded every cycle.
- din  in  W  data bus input.
- cin_n  in  1  active-low count enable (carry-in).
- aq  in  W  current address counter value, from counter dout.
- a_pl  out  1  address counter parallel-load.
- a_di  out  W  address counter load data.
- a_encnt  out  1  address counter enable.
- a_ci  out  1  address counter carry-in (active-low).
- a_inc  out  1  address counter increment.
- a_dec  out  1  address counter decrement.
- done  out  1  transfer complete.
- dout  out  W  read-back data.
- oe  out  1  dout valid.

Behaviour:
- Instruction codes (am2940_pkg):
  - 0 WR_CR: write control register.
  - 1 RD_CR: read control register.
  - 2 RD_WC: read word counter.
  - 3 RD_AC: read address counter.
  - 4 REINIT: reinitialise counters.
  - 5 LD_ADDR: load address.
  - 6 LD_WC: load word count.
  - 7 ENABLE: enable counting.
- Registers: cr[2:0], addr_reg[W], wc_reg[W], wc[W]. All are 0 while reset is low; the async clear dominates any instruction.
- Control register fields:
  - cr[1:0] mode: 00 WC_DOWN, 01 WC_UP_CMP, 10 ADDR_CMP, 11 WC_WRAP.
  - cr[2] address direction: 0 increment, 1 decrement.
- Register updates (posedge clk, reset high):
  - WR_CR: cr <= din[2:0]. If the new mode is WC_UP_CMP, wc <= 0.
  - LD_ADDR: addr_reg <= din.
  - LD_WC: wc_reg <= din. wc <= 0 if the current mode is WC_UP_CMP, else wc <= din.
  - REINIT: wc <= 0 if mode is WC_UP_CMP, else wc <= wc_reg. addr_reg and wc_reg are unchanged.
  - ENABLE with cin_n=0 and done=0 (or mode WC_WRAP): wc counts. WC_UP_CMP increments; WC_DOWN and WC_WRAP decrement modulo 2^W; ADDR_CMP holds.
  - ENABLE with cin_n=1: no change.
  - All other instructions leave registers unchanged.
- Address counter drive (combinational from instr and cr):
  - a_pl = 1 for LD_ADDR or REINIT.
  - a_di = addr_reg when instr is REINIT, else din. The counter loads din in the same edge that addr_reg captures it.
  - a_encnt = 1 when instr is ENABLE and counting is not stopped.
  - a_ci = cin_n.
  - a_inc = !cr[2]; a_dec = cr[2].
- Stop rule: once done=1 in WC_DOWN, WC_UP_CMP or ADDR_CMP, a_encnt=0 and wc holds. The counters freeze until REINIT, LD_WC, LD_ADDR or WR_CR clears the condition.
- DONE (combinational from registered state):
  - WC_DOWN: done = (wc == 0).
  - WC_UP_CMP: done = (wc == wc_reg).
  - ADDR_CMP: done = (aq == wc_reg).
  - WC_WRAP: done = 1 for exactly the cycle in which wc == 0 and instr=ENABLE and cin_n=0. This is a pulse marking the wrap edge; counting never stops.
- After reset: mode WC_DOWN with wc=0, so done=1 and ENABLE has no effect until a word count is loaded.
- Read-back:
  - oe = 1 for RD_CR, RD_WC and RD_AC.
  - dout is {0, cr} for RD_CR, wc for RD_WC, aq for RD_AC, and 0 otherwise.
  - Reads are combinational with zero latency and have no side effects.
- Boundaries:
  - wc wraps 0→FF only in WC_WRAP.
  - WC_UP_CMP with wc_reg=0 is done immediately.
  - A mode change via WR_CR takes effect for done in the next cycle.
- Reset low mid-transfer: all registers return to 0 at once.

Decomposition:
- am2940_pkg holds:
  - the instr_t enum for the 8 instruction codes;
  - the mode_t enum for the 4 modes;
  - the CR bit-position constants.
- One sub-module, am2940_word_cnt, contains wc_reg, wc, the mode-dependent count logic and done. am2940_ctrl instantiates it together with the decoder, cr, addr_reg and the read mux.

Test Plan:
- Reset low mid-ENABLE stream → cr=0, wc=0, oe=0, done=1, a_encnt=0 while in reset and on release.
- WR_CR din=0; LD_WC 3; LD_ADDR 10; then 3×ENABLE with cin_n=0 → wc 3→2→1→0, done rises after the third edge, a_encnt=0 on the fourth ENABLE; RD_AC returns aq.
- WR_CR din=5 (WC_UP_CMP, decrement); LD_WC 2; 2×ENABLE → wc 0→1→2, done=1, a_dec=1, a_inc=0; REINIT → wc=0, done=0, a_pl=1, a_di=addr_reg.
- WR_CR din=2 (ADDR_CMP); LD_WC 20; drive aq 18,19,20 → done=1 only at aq=20; wc unchanged.
- WR_CR din=3 (WC_WRAP); LD_WC 1; 3×ENABLE → wc 1→0→FF→FE; done pulses one cycle at wc=0 while ENABLE; counting continues.
- ENABLE with cin_n=1 → wc unchanged and a_ci=1; RD_CR/RD_WC → oe=1, dout={0,cr}/wc.
